// File: rtl/dmem_stage_ws_if.sv
// Memory-stage bus between the M pipeline register, the dmem stage and the W register / hazard unit.
// The master side is the pipeline, which drives the M_* fields. The slave side is the memory stage.
interface dmem_stage_ws_if;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [3:0]  m_stat;
  logic [3:0]  m_icode;
  logic [63:0] m_valE;
  logic [63:0] m_valM;
  logic [3:0]  m_dstE;
  logic [3:0]  m_dstM;
  logic        M_cndfwd;
  logic [63:0] M_valAfwd;
  logic [63:0] M_valEfwd;
  logic        m_stall;

  modport master (
    output M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
    input  m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
           M_cndfwd, M_valAfwd, M_valEfwd, m_stall
  );

  modport slave (
    input  M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM,
    output m_stat, m_icode, m_valE, m_valM, m_dstE, m_dstM,
           M_cndfwd, M_valAfwd, M_valEfwd, m_stall
  );
endinterface

// File: rtl/dmem_stage_ws.sv
// Y86-64 memory stage: quadword data memory with WAIT_STATES extra cycles per good access.
// Optional macro DMEM_ALIGN_CHECK_EN turns any address with addr[2:0] != 0 into an ADR fault.
module dmem_stage_ws #(
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 0
) (
  input  logic           clk,
  input  logic           rst,
  dmem_stage_ws_if.slave bus
);
  localparam int             IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_L  = DEPTH[IDX_W:0];
  localparam logic [3:0]     WS       = WAIT_STATES[3:0];
  localparam logic [3:0]     STAT_AOK = 4'b0001;
  localparam logic [3:0]     STAT_ADR = 4'b1000;

  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  logic [63:0]      mem [DEPTH];
  logic             is_write;
  logic             is_read;
  logic             use_vala;
  logic             stat_ok;
  logic             is_access;
  logic             addr_bad;
  logic             misalign;
  logic             addr_err;
  logic             access_good;
  logic             complete;
  logic             mem_we;
  logic             stall;
  logic [63:0]      addr;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cnt_reg;
  logic [3:0]       cnt_next;

  // Pass-through fields stay combinational, even during reset.
  assign bus.m_icode   = bus.M_icode;
  assign bus.m_valE    = bus.M_valE;
  assign bus.m_dstE    = bus.M_dstE;
  assign bus.m_dstM    = bus.M_dstM;
  assign bus.M_cndfwd  = bus.M_cnd;
  assign bus.M_valAfwd = bus.M_valA;
  assign bus.M_valEfwd = bus.M_valE;

  always_comb begin
    is_write = (bus.M_icode == I_RMMOVQ) || (bus.M_icode == I_CALL) || (bus.M_icode == I_PUSHQ);
    is_read  = (bus.M_icode == I_MRMOVQ) || (bus.M_icode == I_RET)  || (bus.M_icode == I_POPQ);
    use_vala = (bus.M_icode == I_RET)    || (bus.M_icode == I_POPQ);
  end

  // ret/popq address the stack through valA; everything else uses valE.
  assign addr     = use_vala ? bus.M_valA : bus.M_valE;
  assign idx      = addr[IDX_W+2:3];
  assign addr_bad = (|addr[63:IDX_W+3]) || ({1'b0, idx} >= DEPTH_L);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |addr[2:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^addr[2:0];
  assign misalign        = 1'b0;
`endif

  assign stat_ok     = (bus.M_stat == STAT_AOK);
  assign is_access   = is_write || is_read;
  assign addr_err    = stat_ok && is_access && (addr_bad || misalign);
  assign access_good = stat_ok && is_access && !addr_bad && !misalign;

  // Once BUSY, the count runs to completion regardless of the inputs.
  // The completion cycle then acts on whatever the inputs are at that point.
  always_comb begin
    cnt_next = cnt_reg;
    stall    = 1'b0;
    complete = 1'b0;
    if (WAIT_STATES == 0) begin
      complete = access_good;
    end else if (cnt_reg == 4'd0) begin
      if (access_good) begin
        stall    = 1'b1;
        cnt_next = 4'd1;
      end
    end else if (cnt_reg < WS) begin
      stall    = 1'b1;
      cnt_next = cnt_reg + 4'd1;
    end else begin
      cnt_next = 4'd0;
      complete = access_good;
    end
    if (rst) begin
      stall    = 1'b0;
      complete = 1'b0;
      cnt_next = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= 4'd0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // The memory is deliberately outside the reset so that its contents survive.
  // A write that is in flight while rst is high is dropped through mem_we.
  assign mem_we = complete && is_write;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= bus.M_valA;
    end
  end

  assign bus.m_valM  = (!rst && access_good && is_read) ? mem[idx] : 64'd0;
  assign bus.m_stat  = addr_err ? (bus.M_stat | STAT_ADR) : bus.M_stat;
  assign bus.m_stall = stall;
endmodule

// File: tb/tb_dmem_stage_ws.sv
// Directed bench for dmem_stage_ws: one instance with zero wait states, one with three.
// Each test task drives its own vectors and checks them inline against hand-computed values.
module tb_dmem_stage_ws;
  logic clk;
  logic rst0;
  logic rst3;
  int   pass_cnt;
  int   total_cnt;

  dmem_stage_ws_if bus0 ();
  dmem_stage_ws_if bus3 ();

  dmem_stage_ws #(.DEPTH(2048), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst0), .bus(bus0));
  dmem_stage_ws #(.DEPTH(2048), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst3), .bus(bus3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic [3:0] stat, input logic [3:0] icode,
                      input logic [63:0] vale, input logic [63:0] vala);
    bus0.M_stat  = stat;
    bus0.M_icode = icode;
    bus0.M_valE  = vale;
    bus0.M_valA  = vala;
  endtask

  task automatic set3(input logic [3:0] stat, input logic [3:0] icode,
                      input logic [63:0] vale, input logic [63:0] vala);
    bus3.M_stat  = stat;
    bus3.M_icode = icode;
    bus3.M_valE  = vale;
    bus3.M_valA  = vala;
  endtask

  task automatic test_reset();
    set0(4'b0001, 4'd5, 64'h10, 64'h0);
    set3(4'b0001, 4'd4, 64'h8, 64'h1);
    @(negedge clk);
    $display("test_reset: inputs held during rst");
    total_cnt++; if (bus0.m_valM !== 64'd0) $display("FAIL rst_valM: got %h want %h", bus0.m_valM, 64'd0); else pass_cnt++;
    total_cnt++; if (bus0.m_icode !== 4'd5) $display("FAIL rst_icode: got %h want %h", bus0.m_icode, 4'd5); else pass_cnt++;
    total_cnt++; if (bus0.m_dstM !== 4'h5) $display("FAIL rst_dstM: got %h want %h", bus0.m_dstM, 4'h5); else pass_cnt++;
    total_cnt++; if (bus0.M_valEfwd !== 64'h10) $display("FAIL rst_valEfwd: got %h want %h", bus0.M_valEfwd, 64'h10); else pass_cnt++;
    total_cnt++; if (bus0.M_cndfwd !== 1'b1) $display("FAIL rst_cndfwd: got %h want %h", bus0.M_cndfwd, 1'b1); else pass_cnt++;
    total_cnt++; if (bus3.m_stall !== 1'b0) $display("FAIL rst_stall: got %h want %h", bus3.m_stall, 1'b0); else pass_cnt++;
    total_cnt++; if (u_ws3.cnt_reg !== 4'd0) $display("FAIL rst_cnt: got %h want %h", u_ws3.cnt_reg, 4'd0); else pass_cnt++;
    tick();
    rst0 = 1'b0;
    rst3 = 1'b0;
    set0(4'b0001, 4'd1, 64'h0, 64'h0);
    set3(4'b0001, 4'd1, 64'h0, 64'h0);
  endtask

  task automatic test_ws0_rw();
    set0(4'b0001, 4'd4, 64'h10, 64'hDEAD);
    @(negedge clk);
    $display("test_ws0_rw: rmmovq valE=0x10 valA=0xDEAD");
    total_cnt++; if (bus0.m_stall !== 1'b0) $display("FAIL ws0_wr_stall: got %h want %h", bus0.m_stall, 1'b0); else pass_cnt++;
    total_cnt++; if (bus0.m_stat !== 4'b0001) $display("FAIL ws0_wr_stat: got %h want %h", bus0.m_stat, 4'b0001); else pass_cnt++;
    tick();
    set0(4'b0001, 4'd5, 64'h10, 64'h0);
    @(negedge clk);
    $display("test_ws0_rw: mrmovq valE=0x10");
    total_cnt++; if (bus0.m_valM !== 64'hDEAD) $display("FAIL ws0_rd_valM: got %h want %h", bus0.m_valM, 64'hDEAD); else pass_cnt++;
    total_cnt++; if (bus0.m_stat !== 4'b0001) $display("FAIL ws0_rd_stat: got %h want %h", bus0.m_stat, 4'b0001); else pass_cnt++;
    total_cnt++; if (bus0.m_stall !== 1'b0) $display("FAIL ws0_rd_stall: got %h want %h", bus0.m_stall, 1'b0); else pass_cnt++;
    total_cnt++; if (bus0.m_valE !== 64'h10) $display("FAIL ws0_rd_valE: got %h want %h", bus0.m_valE, 64'h10); else pass_cnt++;
    tick();
    set0(4'b0001, 4'd11, 64'h18, 64'h10);
    @(negedge clk);
    $display("test_ws0_rw: popq valA=0x10");
    total_cnt++; if (bus0.m_valM !== 64'hDEAD) $display("FAIL ws0_popq_valM: got %h want %h", bus0.m_valM, 64'hDEAD); else pass_cnt++;
    total_cnt++; if (bus0.M_valAfwd !== 64'h10) $display("FAIL ws0_valAfwd: got %h want %h", bus0.M_valAfwd, 64'h10); else pass_cnt++;
    tick();
    set0(4'b0001, 4'd1, 64'h10, 64'h10);
    @(negedge clk);
    $display("test_ws0_rw: nop");
    total_cnt++; if (bus0.m_valM !== 64'd0) $display("FAIL ws0_nop_valM: got %h want %h", bus0.m_valM, 64'd0); else pass_cnt++;
    tick();
  endtask

  task automatic test_wait_states();
    set3(4'b0001, 4'd4, 64'h40, 64'h1111);
    repeat (4) tick();
    set3(4'b0001, 4'd10, 64'h40, 64'h1234);
    $display("test_wait_states: pushq valE=0x40 valA=0x1234");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total_cnt++; if (bus3.m_stall !== (i < 4)) $display("FAIL ws3_push_stall[%0d]: got %h want %h", i, bus3.m_stall, (i < 4)); else pass_cnt++;
      total_cnt++; if (u_ws3.mem[8] !== 64'h1111) $display("FAIL ws3_push_early[%0d]: got %h want %h", i, u_ws3.mem[8], 64'h1111); else pass_cnt++;
      tick();
    end
    total_cnt++; if (u_ws3.mem[8] !== 64'h1234) $display("FAIL ws3_push_commit: got %h want %h", u_ws3.mem[8], 64'h1234); else pass_cnt++;
    total_cnt++; if (u_ws3.cnt_reg !== 4'd0) $display("FAIL ws3_push_cnt: got %h want %h", u_ws3.cnt_reg, 4'd0); else pass_cnt++;
    set3(4'b0001, 4'd5, 64'h40, 64'h0);
    $display("test_back_to_back: mrmovq valE=0x40");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      total_cnt++; if (bus3.m_stall !== (i < 4)) $display("FAIL b2b_stall[%0d]: got %h want %h", i, bus3.m_stall, (i < 4)); else pass_cnt++;
      if (i == 4) begin
        total_cnt++; if (bus3.m_valM !== 64'h1234) $display("FAIL b2b_valM: got %h want %h", bus3.m_valM, 64'h1234); else pass_cnt++;
        total_cnt++; if (bus3.m_stat !== 4'b0001) $display("FAIL b2b_stat: got %h want %h", bus3.m_stat, 4'b0001); else pass_cnt++;
      end
      tick();
    end
    set3(4'b0001, 4'd1, 64'h0, 64'h0);
  endtask

  task automatic test_bad_addr();
    set0(4'b0001, 4'd4, 64'h0, 64'hAAAA);
    tick();
    set0(4'b0001, 4'd5, 64'h4000, 64'h0);
    @(negedge clk);
    $display("test_bad_addr: mrmovq valE=DEPTH*8");
    total_cnt++; if (bus0.m_stat !== 4'b1001) $display("FAIL bad_mr_stat: got %h want %h", bus0.m_stat, 4'b1001); else pass_cnt++;
    total_cnt++; if (bus0.m_valM !== 64'd0) $display("FAIL bad_mr_valM: got %h want %h", bus0.m_valM, 64'd0); else pass_cnt++;
    tick();
    set0(4'b0001, 4'd11, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8);
    @(negedge clk);
    $display("test_bad_addr: popq valA=0xFFFFFFFFFFFFFFF8");
    total_cnt++; if (bus0.m_stat !== 4'b1001) $display("FAIL bad_pop_stat: got %h want %h", bus0.m_stat, 4'b1001); else pass_cnt++;
    total_cnt++; if (bus0.m_valM !== 64'd0) $display("FAIL bad_pop_valM: got %h want %h", bus0.m_valM, 64'd0); else pass_cnt++;
    tick();
    set0(4'b0001, 4'd4, 64'h4000, 64'hBAD);
    @(negedge clk);
    $display("test_bad_addr: rmmovq valE=DEPTH*8 valA=0xBAD");
    total_cnt++; if (bus0.m_stat !== 4'b1001) $display("FAIL bad_wr_stat: got %h want %h", bus0.m_stat, 4'b1001); else pass_cnt++;
    tick();
    set0(4'b0001, 4'd5, 64'h0, 64'h0);
    @(negedge clk);
    $display("test_bad_addr: mrmovq valE=0 after dropped write");
    total_cnt++; if (bus0.m_valM !== 64'hAAAA) $display("FAIL bad_no_write: got %h want %h", bus0.m_valM, 64'hAAAA); else pass_cnt++;
    tick();
    set3(4'b0001, 4'd5, 64'h4000, 64'h0);
    @(negedge clk);
    $display("test_bad_addr: ws3 mrmovq valE=DEPTH*8");
    total_cnt++; if (bus3.m_stall !== 1'b0) $display("FAIL bad_ws3_stall: got %h want %h", bus3.m_stall, 1'b0); else pass_cnt++;
    total_cnt++; if (bus3.m_stat !== 4'b1001) $display("FAIL bad_ws3_stat: got %h want %h", bus3.m_stat, 4'b1001); else pass_cnt++;
    tick();
    total_cnt++; if (u_ws3.cnt_reg !== 4'd0) $display("FAIL bad_ws3_cnt: got %h want %h", u_ws3.cnt_reg, 4'd0); else pass_cnt++;
    set3(4'b0001, 4'd1, 64'h0, 64'h0);
  endtask

  task automatic test_halt();
    set0(4'b0001, 4'd4, 64'h8, 64'h7777);
    tick();
    set0(4'b0010, 4'd4, 64'h8, 64'h5555);
    @(negedge clk);
    $display("test_halt: HLT rmmovq valE=0x8");
    total_cnt++; if (bus0.m_stat !== 4'b0010) $display("FAIL hlt_stat: got %h want %h", bus0.m_stat, 4'b0010); else pass_cnt++;
    total_cnt++; if (bus0.m_stall !== 1'b0) $display("FAIL hlt_stall: got %h want %h", bus0.m_stall, 1'b0); else pass_cnt++;
    tick();
    set0(4'b0001, 4'd5, 64'h8, 64'h0);
    @(negedge clk);
    $display("test_halt: mrmovq valE=0x8");
    total_cnt++; if (bus0.m_valM !== 64'h7777) $display("FAIL hlt_no_write: got %h want %h", bus0.m_valM, 64'h7777); else pass_cnt++;
    tick();
    set3(4'b0010, 4'd5, 64'h8, 64'h0);
    @(negedge clk);
    $display("test_halt: ws3 HLT mrmovq");
    total_cnt++; if (bus3.m_stall !== 1'b0) $display("FAIL hlt_ws3_stall: got %h want %h", bus3.m_stall, 1'b0); else pass_cnt++;
    total_cnt++; if (bus3.m_valM !== 64'd0) $display("FAIL hlt_ws3_valM: got %h want %h", bus3.m_valM, 64'd0); else pass_cnt++;
    tick();
    set3(4'b0001, 4'd1, 64'h0, 64'h0);
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp_words [2];
    exp_words[0] = 64'h3333;
    exp_words[1] = 64'h4444;
    set3(4'b0001, 4'd4, 64'h18, 64'h3333);
    repeat (4) tick();
    set3(4'b0001, 4'd4, 64'h20, 64'h4444);
    repeat (4) tick();
    set3(4'b0001, 4'd4, 64'h18, 64'h9999);
    $display("test_reset_mid: rmmovq valE=0x18 valA=0x9999, rst in 2nd stall cycle");
    @(negedge clk);
    total_cnt++; if (bus3.m_stall !== 1'b1) $display("FAIL rmid_stall1: got %h want %h", bus3.m_stall, 1'b1); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if (bus3.m_stall !== 1'b1) $display("FAIL rmid_stall2: got %h want %h", bus3.m_stall, 1'b1); else pass_cnt++;
    rst3 = 1'b1;
    #1;
    total_cnt++; if (bus3.m_stall !== 1'b0) $display("FAIL rmid_stall_rst: got %h want %h", bus3.m_stall, 1'b0); else pass_cnt++;
    total_cnt++; if (u_ws3.cnt_reg !== 4'd0) $display("FAIL rmid_cnt: got %h want %h", u_ws3.cnt_reg, 4'd0); else pass_cnt++;
    tick();
    rst3 = 1'b0;
    for (int w = 0; w < 2; w++) begin
      set3(4'b0001, 4'd5, (w == 0) ? 64'h18 : 64'h20, 64'h0);
      $display("test_reset_mid: mrmovq word %0d", 3 + w);
      for (int i = 1; i <= 4; i++) begin
        @(negedge clk);
        if (i == 4) begin
          total_cnt++; if (bus3.m_valM !== exp_words[w]) $display("FAIL rmid_word%0d: got %h want %h", 3 + w, bus3.m_valM, exp_words[w]); else pass_cnt++;
        end
        tick();
      end
    end
    set3(4'b0001, 4'd1, 64'h0, 64'h0);
  endtask

  task automatic test_align();
    set0(4'b0001, 4'd5, 64'h13, 64'h0);
    @(negedge clk);
    $display("test_align: mrmovq valE=0x13");
`ifdef DMEM_ALIGN_CHECK_EN
    total_cnt++; if (bus0.m_stat !== 4'b1001) $display("FAIL align_stat: got %h want %h", bus0.m_stat, 4'b1001); else pass_cnt++;
    total_cnt++; if (bus0.m_valM !== 64'd0) $display("FAIL align_valM: got %h want %h", bus0.m_valM, 64'd0); else pass_cnt++;
`else
    total_cnt++; if (bus0.m_stat !== 4'b0001) $display("FAIL align_stat: got %h want %h", bus0.m_stat, 4'b0001); else pass_cnt++;
    total_cnt++; if (bus0.m_valM !== 64'hDEAD) $display("FAIL align_valM: got %h want %h", bus0.m_valM, 64'hDEAD); else pass_cnt++;
`endif
    tick();
    set0(4'b0001, 4'd1, 64'h0, 64'h0);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst0 = 1'b1;
    rst3 = 1'b1;
    bus0.M_cnd  = 1'b1;
    bus0.M_dstE = 4'hF;
    bus0.M_dstM = 4'h5;
    bus3.M_cnd  = 1'b0;
    bus3.M_dstE = 4'h2;
    bus3.M_dstM = 4'h3;
    set0(4'b0001, 4'd1, 64'h0, 64'h0);
    set3(4'b0001, 4'd1, 64'h0, 64'h0);
    test_reset();
    test_ws0_rw();
    test_wait_states();
    test_bad_addr();
    test_halt();
    test_reset_mid();
    test_align();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
